i2s_clk_seq: RTL and testbench

- Sequencer/controller for the I2S clock divider and its frame timing.
- Owns the active operating configuration (OP_t) driven to the divider.
- Applies configuration changes only at frame boundaries, with a gated dead period.
- Derives per-bit sclk enables, word-select (ws) and frame-start strobes from mclk, so the transmitter and receiver datapaths run on mclk with enables.

---
 rtl/i2s_clk_seq_if.sv | 52 +++++
 rtl/i2s_clk_seq.sv | 178 +++++++++++++++++
 tb/tb_i2s_clk_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_clk_seq_if.sv
// ---------------------------------------------------------------------------
// i2s_clk_seq_pkg / i2s_clk_seq_if
// Purpose : operating-configuration type for the I2S clock sequencer and the
//           interface bundling its control/status signals.
// op_t    : mclk_en - 1 = divide mclk into bits, 0 = one bit per mclk
//           stereo  - 1 = two words per frame, 0 = mono (one word per frame)
//           f32bits - 1 = 32-bit words, 0 = 16-bit words (f16bits)
// Signals : run, cfg_req, cfg_op (requester -> sequencer)
//           cfg_ack, op_act, div_gate_n, sclk_en, ws, frame_start, busy
//           (sequencer -> consumers)
//           cfg_abort (requester -> sequencer) only with I2S_SEQ_ABORT_EN
// Modports: master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
package i2s_clk_seq_pkg;
  typedef struct packed {
    logic mclk_en;
    logic stereo;
    logic f32bits;
  } op_t;
endpackage

interface i2s_clk_seq_if;
  import i2s_clk_seq_pkg::*;

  logic run;
  logic cfg_req;
  op_t  cfg_op;
  logic cfg_ack;
  op_t  op_act;
  logic div_gate_n;
  logic sclk_en;
  logic ws;
  logic frame_start;
  logic busy;
`ifdef I2S_SEQ_ABORT_EN
  logic cfg_abort;

  modport master (output run, cfg_req, cfg_op, cfg_abort,
                  input  cfg_ack, op_act, div_gate_n, sclk_en, ws,
                         frame_start, busy);
  modport slave  (input  run, cfg_req, cfg_op, cfg_abort,
                  output cfg_ack, op_act, div_gate_n, sclk_en, ws,
                         frame_start, busy);
`else
  modport master (output run, cfg_req, cfg_op,
                  input  cfg_ack, op_act, div_gate_n, sclk_en, ws,
                         frame_start, busy);
  modport slave  (input  run, cfg_req, cfg_op,
                  output cfg_ack, op_act, div_gate_n, sclk_en, ws,
                         frame_start, busy);
`endif
endinterface

// File: rtl/i2s_clk_seq.sv
// ---------------------------------------------------------------------------
// i2s_clk_seq
// Purpose : sequencer for the I2S clock divider. Owns the active operating
//           configuration, swaps it only at frame boundaries behind a gated
//           dead period, and derives per-bit sclk enables, word select and
//           frame-start strobes on mclk.
// Ports   : mclk - master clock (posedge)
//           rst_ - asynchronous active-low reset
//           bus  - i2s_clk_seq_if.slave (run/cfg_req/cfg_op in;
//                  cfg_ack/op_act/div_gate_n/sclk_en/ws/frame_start/busy out)
// Params  : DEAD_CYC - gated mclk cycles between configurations (>= 2)
//           CNT_W    - width of the mclk-per-bit and bit-in-word counters
// Option  : I2S_SEQ_ABORT_EN - adds cfg_abort; cfg_req+cfg_abort in RUN or
//           DRAIN truncates the current frame and gates immediately.
// ---------------------------------------------------------------------------
module i2s_clk_seq
  import i2s_clk_seq_pkg::*;
#(
  parameter int DEAD_CYC = 8,
  parameter int CNT_W    = 5
) (
  input logic         mclk,
  input logic         rst_,
  i2s_clk_seq_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] GATE  = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;

  localparam int GCNT_W = (DEAD_CYC > 2) ? $clog2(DEAD_CYC) : 1;

  logic [2:0]        state;
  op_t               op_act;
  op_t               pend_op;
  logic              pend_vld;
  logic              stop_flg;
  logic [CNT_W-1:0]  mcnt;
  logic [CNT_W-1:0]  bcnt;
  logic              ch;
  logic [GCNT_W-1:0] gcnt;

  logic [CNT_W-1:0]  r_last;
  logic [CNT_W-1:0]  w_last;
  logic              counting;
  logic              sclk_en_i;
  logic              frame_end;
  logic              abort_req;

  // Last mclk index of a bit (R-1) and last bit index of a word (W-1).
  always_comb begin
    r_last = CNT_W'(7);
    if (!op_act.mclk_en)
      r_last = '0;
    else if (!op_act.stereo && !op_act.f32bits)
      r_last = CNT_W'(15);
    else if (op_act.stereo && op_act.f32bits)
      r_last = CNT_W'(3);
    w_last = op_act.f32bits ? CNT_W'(31) : CNT_W'(15);
  end

  assign counting  = (state == RUN) || (state == DRAIN);
  assign sclk_en_i = counting && (mcnt == r_last);
  assign frame_end = sclk_en_i && (bcnt == w_last) && (ch || !op_act.stereo);

`ifdef I2S_SEQ_ABORT_EN
  assign abort_req = counting && bus.cfg_req && bus.cfg_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Bit/word counters. They only move while bits are being produced; an
  // abort clears them on the way into GATE so ws is already back at 0.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      mcnt <= '0;
      bcnt <= '0;
      ch   <= 1'b0;
    end else if (!counting || abort_req) begin
      mcnt <= '0;
      bcnt <= '0;
      ch   <= 1'b0;
    end else if (mcnt == r_last) begin
      mcnt <= '0;
      if (bcnt == w_last) begin
        bcnt <= '0;
        ch   <= op_act.stereo ? ~ch : 1'b0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end else begin
      mcnt <= mcnt + 1'b1;
    end
  end

  // Control FSM. The stop flag follows the inverted run level while a change
  // is in flight, so a late run rise cancels the stop and a late run fall
  // still lands in IDLE. A stop with a pending config loads it first.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      op_act   <= '{default: 1'b0};
      pend_op  <= '{default: 1'b0};
      pend_vld <= 1'b0;
      stop_flg <= 1'b0;
      gcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          gcnt <= '0;
          if (bus.cfg_req) begin
            pend_op  <= bus.cfg_op;
            pend_vld <= 1'b1;
            stop_flg <= ~bus.run;
            state    <= GATE;
          end else if (bus.run) begin
            stop_flg <= 1'b0;
            state    <= LOAD;
          end
        end
        RUN: begin
          stop_flg <= ~bus.run;
          if (bus.cfg_req) begin
            pend_op  <= bus.cfg_op;
            pend_vld <= 1'b1;
          end
          if (abort_req)
            state <= GATE;
          else if (bus.cfg_req || !bus.run)
            state <= DRAIN;
        end
        DRAIN: begin
          stop_flg <= ~bus.run;
          if (bus.cfg_req) begin
            pend_op  <= bus.cfg_op;
            pend_vld <= 1'b1;
          end
          if (abort_req || frame_end)
            state <= GATE;
        end
        GATE: begin
          stop_flg <= ~bus.run;
          if (bus.cfg_req) begin
            pend_op  <= bus.cfg_op;
            pend_vld <= 1'b1;
          end
          if (gcnt == GCNT_W'(DEAD_CYC - 1)) begin
            gcnt <= '0;
            if (!bus.run && !pend_vld && !bus.cfg_req)
              state <= IDLE;
            else
              state <= LOAD;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        LOAD: begin
          if (pend_vld)
            op_act <= pend_op;
          pend_vld <= 1'b0;
          state    <= stop_flg ? IDLE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_act      = op_act;
  assign bus.div_gate_n  = counting;
  assign bus.sclk_en     = sclk_en_i;
  assign bus.ws          = ch;
  assign bus.frame_start = sclk_en_i && (bcnt == '0) && !ch;
  assign bus.busy        = (state == DRAIN) || (state == GATE) || (state == LOAD);
  assign bus.cfg_ack     = (state == LOAD) && pend_vld;

endmodule

// File: tb/tb_i2s_clk_seq.sv
// ---------------------------------------------------------------------------
// tb_i2s_clk_seq
// Purpose : self-checking bench for i2s_clk_seq. Expected outputs come from
//           the bit-timing rules computed arithmetically from the elapsed
//           cycle count since the sequencer entered RUN.
// Option  : I2S_SEQ_ABORT_EN adds the abort scenario.
// ---------------------------------------------------------------------------
module tb_i2s_clk_seq;
  import i2s_clk_seq_pkg::*;

  localparam int DEAD = 8;

  localparam op_t S16    = 3'b110;
  localparam op_t M16    = 3'b100;
  localparam op_t S32    = 3'b111;
  localparam op_t M32    = 3'b101;
  localparam op_t S32RAW = 3'b011;
  localparam op_t ZERO   = 3'b000;

  logic mclk = 1'b0;
  logic rst_ = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  i2s_clk_seq_if bus();

  i2s_clk_seq #(.DEAD_CYC(DEAD), .CNT_W(5)) dut (
    .mclk (mclk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  function automatic int ratio(input op_t o);
    if (!o.mclk_en)                 return 1;
    if (!o.stereo && !o.f32bits)    return 16;
    if (o.stereo && o.f32bits)      return 4;
    return 8;
  endfunction

  function automatic int wlen(input op_t o);
    return o.f32bits ? 32 : 16;
  endfunction

  function automatic int frame_bits(input op_t o);
    return o.stereo ? 2 * wlen(o) : wlen(o);
  endfunction

  function automatic int frame_cyc(input op_t o);
    return ratio(o) * frame_bits(o);
  endfunction

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input op_t op, input logic r,
                               input logic ab);
    bus.cfg_req = req;
    bus.cfg_op  = op;
    bus.run     = r;
`ifdef I2S_SEQ_ABORT_EN
    bus.cfg_abort = ab;
`else
    if (ab) $display("[TB] abort request ignored in this build");
`endif
  endtask

  // Output vector: {div_gate_n, busy, cfg_ack, sclk_en, ws, frame_start, op_act}
  task automatic checkOutput(input string tag, input int n, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {bus.div_gate_n, bus.busy, bus.cfg_ack, bus.sclk_en, bus.ws,
           bus.frame_start, bus.op_act};
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  // Starts on the first RUN cycle of configuration op. Issues a request at
  // RUN cycle q (cfg change and/or run drop, optionally with abort), an
  // optional second request at GATE offset g2, an optional reset at GATE
  // offset rst_at, and follows the sequencer through GATE and LOAD (and IDLE
  // when stopping).
  task automatic trackRun(input string tag, input op_t op, input int q,
                          input bit have_cfg, input op_t rop, input bit drop_run,
                          input bit abort, input int g2, input op_t rop2,
                          input int rst_at);
    int  rr, w, fb, len, bnd, bit_i;
    bit  sclk, wsx, fs;
    op_t nop;
    rr  = ratio(op);
    w   = wlen(op);
    fb  = frame_bits(op);
    len = rr * fb;
    bnd = abort ? q + 1 : ((q + 1) / len + 1) * len;
    nop = (g2 >= 0) ? rop2 : rop;
    for (int n = 0; n < 20000; n++) begin
      step;
      bus.cfg_req = 1'b0;
`ifdef I2S_SEQ_ABORT_EN
      bus.cfg_abort = 1'b0;
`endif
      if (n < bnd) begin
        bit_i = n / rr;
        sclk  = (n % rr) == rr - 1;
        wsx   = op.stereo && (((bit_i / w) % 2) == 1);
        fs    = sclk && ((bit_i % fb) == 0);
        checkOutput(tag, n, {1'b1, (n > q), 1'b0, sclk, wsx, fs, op});
        if (n == q) applyStimulus(have_cfg, rop, !drop_run, abort);
      end else if (n < bnd + DEAD) begin
        checkOutput(tag, n, {6'b010000, op});
        if (n - bnd == rst_at) begin
          applyStimulus(1'b0, op, 1'b0, 1'b0);
          rst_ = 1'b0;
          #1;
          checkOutput({tag, "_rst"}, n, {6'b000000, ZERO});
          step;
          rst_ = 1'b1;
          for (int k = 0; k < 4; k++) begin
            step;
            checkOutput({tag, "_after_rst"}, n + k, {6'b000000, ZERO});
          end
          return;
        end
        if (n - bnd == g2) applyStimulus(1'b1, rop2, !drop_run, 1'b0);
      end else if (n == bnd + DEAD) begin
        if (drop_run && !have_cfg) begin
          checkOutput({tag, "_idle"}, n, {6'b000000, op});
          return;
        end
        checkOutput({tag, "_load"}, n, {2'b01, have_cfg, 3'b000, op});
        if (!drop_run) return;
      end else begin
        checkOutput({tag, "_idle"}, n, {6'b000000, nop});
        return;
      end
    end
    n_cmp++;
    n_mis++;
    $error("[TB] FAIL %s: cycle budget exhausted", tag);
  endtask

  task automatic restartFromIdle(input string tag, input op_t op);
    applyStimulus(1'b0, op, 1'b1, 1'b0);
    step;
    checkOutput(tag, 0, {6'b010000, op});
  endtask

  initial begin
    op_t cur, nxt;
    applyStimulus(1'b0, ZERO, 1'b0, 1'b0);
    rst_ = 1'b0;
    step;
    step;
    checkOutput("reset_held", 0, {6'b000000, ZERO});
    rst_ = 1'b1;
    step;
    checkOutput("reset_idle", 0, {6'b000000, ZERO});

    // First configuration loaded straight from IDLE.
    applyStimulus(1'b1, S16, 1'b1, 1'b0);
    for (int k = 1; k <= DEAD; k++) begin
      step;
      bus.cfg_req = 1'b0;
      checkOutput("init_gate", k, {6'b010000, ZERO});
    end
    step;
    checkOutput("init_load", DEAD + 1, {6'b011000, ZERO});

    // stereo/f16 -> mono/f16, request at bit 5 of the left word.
    trackRun("s16_to_m16", S16, 5 * 8 + 3, 1'b1, M16, 1'b0, 1'b0, -1, ZERO, -1);

    // Drain request stereo/f32 overwritten in GATE by mono/f32.
    trackRun("m16_to_m32", M16, $urandom_range(0, 511), 1'b1, S32, 1'b0, 1'b0,
             $urandom_range(0, DEAD - 1), M32, -1);

    // mono/f32 -> stereo/f32 without mclk division.
    trackRun("m32_to_raw", M32, $urandom_range(0, 511), 1'b1, S32RAW, 1'b0, 1'b0,
             -1, ZERO, -1);

    // run dropped mid-frame: frame completes, gate, IDLE, restart.
    trackRun("raw_stop", S32RAW, $urandom_range(0, 127), 1'b0, ZERO, 1'b1, 1'b0,
             -1, ZERO, -1);
    restartFromIdle("raw_restart", S32RAW);

    // cfg_req together with run falling: load, then idle with the new config.
    nxt = 3'($urandom_range(0, 7));
    trackRun("raw_stop_cfg", S32RAW, $urandom_range(0, 127), 1'b1, nxt, 1'b1,
             1'b0, -1, ZERO, -1);
    restartFromIdle("cfg_restart", nxt);
    cur = nxt;

    for (int i = 0; i < 4; i++) begin
      nxt = 3'($urandom_range(0, 7));
      trackRun("random_cfg", cur, $urandom_range(0, 2 * frame_cyc(cur) - 1), 1'b1,
               nxt, 1'b0, 1'b0, -1, ZERO, -1);
      cur = nxt;
    end

`ifdef I2S_SEQ_ABORT_EN
    nxt = 3'($urandom_range(0, 7));
    trackRun("abort", cur, 3 * ratio(cur) + 1, 1'b1, nxt, 1'b0, 1'b1, -1, ZERO, -1);
    cur = nxt;
`endif

    // Reset while gated with a pending configuration.
    trackRun("rst_gate", cur, $urandom_range(0, frame_cyc(cur) - 1), 1'b1, S16,
             1'b0, 1'b0, -1, ZERO, $urandom_range(0, DEAD - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
